mux5_rr_arbiter: RTL and testbench
==================================

// Module: mux5_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one 5:1 32-bit select mux between five requesters.
//  Drives the 3-bit mux select and a registered one-hot grant, and presents the muxed beat
//  downstream with valid/ready. Supports bounded bursts per grant.
//  Sits directly in front of the 5-input result mux; the mux itself stays external.
// PARAMETERS
//  MAX_BURST   4    max beats accepted per grant before forced hand-off (1..15)
//  TIMEOUT_CYC 16   stall cycles (valid & !ready) before grant is revoked; ARB_TIMEOUT_EN only
// PORTS
//  clk        in   1  clock, rising edge
//  rst_n      in   1  asynchronous active-low reset
//  req        in   5  req[i]: requester i has a beat on mux input i (Src(i+1))
//  last       in   5  last[i]: current beat of requester i ends its burst
//  out_ready  in   1  downstream accepts beat
//  select     out  3  mux select, registered; 3'd7 when idle (mux drives 0)
//  gnt        out  5  registered one-hot grant
//  ack        out  5  gnt & {5{out_ready}}, combinational; beat i accepted this cycle
//  out_valid  out  1  muxed data valid (= state==GRANT)
//  timeout    out  1  1-cycle pulse when a grant is revoked by timeout
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - state=IDLE, select=3'd7, gnt=0, ptr=0, beat_cnt=0, stall_cnt=0, timeout=0.
//  - out_valid=0 and ack=0 while reset is held.
//  - Reset mid-burst drops the grant immediately; no ack is issued.
//  States: IDLE, GRANT.
//  IDLE:
//  - If req!=0, pick the first set bit scanning ptr, ptr+1, .., 4, 0, .., ptr-1.
//  - Register select=idx, gnt=1<<idx, beat_cnt=0, stall_cnt=0; go to GRANT.
//  - Latency: req rising in cycle N gives out_valid=1 in cycle N+1.
//  - If req==0: stay in IDLE; select=7, gnt=0.
//  GRANT (out_valid=1):
//  - Accept: out_ready=1 -> ack[select]=1, beat_cnt++, stall_cnt=0.
//  - End of grant on accept when last[select]=1 or beat_cnt==MAX_BURST-1.
//  - Abort: req[select]=0 with no accept ends the grant; no ack.
//  - On end/abort: ptr = select==4 ? 0 : select+1; state=IDLE; select=7; gnt=0.
//  - One idle bubble cycle always separates grants (no back-to-back re-arbitration).
//  - Accept without end: stay in GRANT with the same select; the requester presents its next beat.
//  Counters:
//  - beat_cnt is 4 bits; it never wraps because it is cleared at grant start and capped by MAX_BURST.
//  - ptr is 3 bits, range 0..4 only; the wrap from 4 goes to 0.
//  Simultaneous events:
//  - last and burst cap in the same cycle is a single end.
//  - Abort has lower precedence than accept: out_ready=1 with req[select]=0 still counts as an accept.
//  - req changes on non-granted lines are ignored until the next IDLE.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//  - stall_cnt increments each GRANT cycle with out_ready=0.
//  - On reaching TIMEOUT_CYC-1 while still stalled, the grant is revoked like an abort:
//    ptr advances, IDLE, timeout=1 for exactly that transition cycle.
//  ARB_TIMEOUT_EN undefined:
//  - No stall counter; the grant waits indefinitely for out_ready.
//  - timeout is tied to 0.
// TESTING
//  1 Reset: rst_n=0 with req=5'h1F -> select=7, gnt=0, out_valid=0; release -> gnt=5'h01 one cycle later.
//  2 Round robin: req=5'h1F, last=5'h1F, out_ready=1 held -> grants 0,1,2,3,4,0,
//    each 1 valid cycle followed by 1 idle cycle.
//  3 Burst cap: MAX_BURST=4, req=5'h05, last=0, out_ready=1 -> 4 acks on requester 0,
//    then bubble, then gnt=5'h04.
//  4 Wrap/skip: ptr=4 (after a grant to 3), req=5'h0A -> next grant is 1 (skips 4, 0), then 3.
//  5 Abort and reset mid-burst: drop req[2] while granted with out_ready=0 -> IDLE next cycle,
//    no ack, ptr=3. Assert rst_n=0 mid-burst -> gnt=0 asynchronously.
//  6 Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYC=16): req=5'h01, out_ready=0 ->
//    timeout pulses once after 16 stalled cycles, gnt=0. Without the macro: no pulse after 100 cycles.

Source files
------------

// File: rtl/mux5_rr_arbiter.sv
// Round-robin arbiter for a shared external 5:1 result mux: registered select/one-hot grant, bounded bursts.
// Optional stall watchdog enabled by defining ARB_TIMEOUT_EN (adds TIMEOUT_CYC parameter).
module mux5_rr_arbiter #(
  parameter int MAX_BURST = 4
`ifdef ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 16
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] req,
  input  logic [4:0] last,
  input  logic       out_ready,
  output logic [2:0] select,
  output logic [4:0] gnt,
  output logic [4:0] ack,
  output logic       out_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     r_state, w_nxt_state;
  logic [2:0] r_sel, w_nxt_sel, r_ptr, w_nxt_ptr, w_pick;
  logic [4:0] r_gnt, w_nxt_gnt;
  logic [3:0] r_beat, w_nxt_beat;
  logic       w_req_sel, w_last_sel, w_accept, w_end, w_release, w_stall_hit;

  // Rotating priority scan; iterating downward lets the entry nearest ptr win.
  always_comb begin
    int idx;
    idx    = 0;
    w_pick = 3'd0;
    for (int k = 4; k >= 0; k--) begin
      idx = int'(r_ptr) + k;
      if (idx >= 5) idx = idx - 5;
      if (req[idx]) w_pick = 3'(idx);
    end
  end

  assign w_req_sel  = |(req & r_gnt);
  assign w_last_sel = |(last & r_gnt);
  assign w_accept   = (r_state == GRANT) && out_ready;
  assign w_end      = w_accept && (w_last_sel || (r_beat == 4'(MAX_BURST - 1)));
  // An accept outranks both abort and timeout, so those only apply while stalled.
  assign w_release  = (r_state == GRANT) &&
                      (w_end || (!out_ready && (!w_req_sel || w_stall_hit)));

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_sel   = r_sel;
    w_nxt_gnt   = r_gnt;
    w_nxt_ptr   = r_ptr;
    w_nxt_beat  = r_beat;
    case (r_state)
      IDLE: begin
        if (req != 5'd0) begin
          w_nxt_state = GRANT;
          w_nxt_sel   = w_pick;
          w_nxt_gnt   = 5'd1 << w_pick;
          w_nxt_beat  = 4'd0;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_nxt_state = IDLE;
          w_nxt_sel   = 3'd7;
          w_nxt_gnt   = 5'd0;
          w_nxt_ptr   = (r_sel == 3'd4) ? 3'd0 : r_sel + 3'd1;
        end else if (w_accept) begin
          w_nxt_beat  = r_beat + 4'd1;
        end
      end
      default: begin
        w_nxt_state = IDLE;
        w_nxt_sel   = 3'd7;
        w_nxt_gnt   = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= 3'd7;
      r_gnt   <= 5'd0;
      r_ptr   <= 3'd0;
      r_beat  <= 4'd0;
    end else begin
      r_state <= w_nxt_state;
      r_sel   <= w_nxt_sel;
      r_gnt   <= w_nxt_gnt;
      r_ptr   <= w_nxt_ptr;
      r_beat  <= w_nxt_beat;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYC + 1);
  logic [SW-1:0] r_stall;
  logic          r_timeout;

  assign w_stall_hit = (r_stall == SW'(TIMEOUT_CYC - 1));

  // Counter idles at zero outside GRANT, so every new grant starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= (r_state == GRANT) && !out_ready && w_req_sel && w_stall_hit;
      if ((r_state != GRANT) || out_ready || w_release) r_stall <= '0;
      else                                              r_stall <= r_stall + 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_stall_hit = 1'b0;
  assign timeout     = 1'b0;
`endif

  assign select    = r_sel;
  assign gnt       = r_gnt;
  assign out_valid = (r_state == GRANT);
  assign ack       = r_gnt & {5{out_ready}};

endmodule

// File: tb/tb_mux5_rr_arbiter.sv
// Bench for mux5_rr_arbiter: queue-free reference model checked every cycle plus directed literal checks.
module tb_mux5_rr_arbiter;
  localparam int MAXB = 4;
  localparam int TOC  = 16;

  logic       clk = 1'b0, rst_n = 1'b1;
  logic [4:0] req = 5'd0, last = 5'd0;
  logic       out_ready = 1'b0;
  logic [2:0] select;
  logic [4:0] gnt, ack;
  logic       out_valid, timeout;

  int n_tot = 0, n_pass = 0;
  bit done = 1'b0;

  mux5_rr_arbiter #(.MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .last(last), .out_ready(out_ready),
    .select(select), .gnt(gnt), .ack(ack), .out_valid(out_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: who owns the mux, how many beats/stalls so far, where the scan starts.
  bit m_busy = 1'b0, m_to = 1'b0;
  int m_own = 0, m_ptr = 0, m_beats = 0, m_stalls = 0;

  task automatic m_release();
    m_busy = 1'b0;
    m_ptr  = (m_own + 1) % 5;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_to = 1'b0; m_ptr = 0; m_beats = 0; m_stalls = 0;
    end else begin
      m_to = 1'b0;
      if (!m_busy) begin
        for (int k = 0; k < 5; k++)
          if (!m_busy && req[(m_ptr + k) % 5]) begin
            m_busy = 1'b1; m_own = (m_ptr + k) % 5; m_beats = 0; m_stalls = 0;
          end
      end else if (out_ready) begin
        m_beats++;
        m_stalls = 0;
        if (last[m_own] || m_beats == MAXB) m_release();
      end else if (!req[m_own]) begin
        m_release();
      end else begin
`ifdef ARB_TIMEOUT_EN
        m_stalls++;
        if (m_stalls == TOC) begin m_release(); m_to = 1'b1; end
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (!done) begin
      chk("m_select",    32'(select),    m_busy ? 32'(m_own) : 32'd7);
      chk("m_gnt",       32'(gnt),       m_busy ? (32'd1 << m_own) : 32'd0);
      chk("m_out_valid", 32'(out_valid), 32'(m_busy));
      chk("m_ack",       32'(ack),       (m_busy && out_ready) ? (32'd1 << m_own) : 32'd0);
      chk("m_timeout",   32'(timeout),   32'(m_to));
    end
  end

  logic [4:0] exp_rr [11];
  int acks, pulses, first;

  initial begin
    exp_rr = '{5'h01, 5'h00, 5'h02, 5'h00, 5'h04, 5'h00, 5'h08, 5'h00, 5'h10, 5'h00, 5'h01};
    // Reset with all requesters active and downstream ready.
    #1 rst_n = 1'b0; req = 5'h1F; last = 5'h1F; out_ready = 1'b1;
    tick(); tick();
    chk("rst_select", 32'(select), 32'd7);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_gnt", 32'(gnt), 32'h01);

    // Single-beat round robin with an idle bubble between grants.
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(exp_rr[i]));
      if (i < 10) tick();
    end
    req = 5'h00; tick();
    req = 5'h10; tick();
    chk("pre_gnt4", 32'(gnt), 32'h10);
    req = 5'h00; tick();

    // Burst cap on requester 0 from ptr=0.
    req = 5'h05; last = 5'h00; tick();
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      if (ack == 5'h01) acks++;
      tick();
    end
    chk("burst_acks", 32'(acks), 32'd4);
    chk("burst_bubble", 32'(gnt), 32'd0);
    tick();
    chk("burst_next", 32'(gnt), 32'h04);

    // Abort: requester 2 drops while stalled.
    req = 5'h00; out_ready = 1'b0;
    #1 chk("abort_ack", 32'(ack), 32'd0);
    tick();
    chk("abort_gnt", 32'(gnt), 32'd0);
    req = 5'h1F; last = 5'h1F; out_ready = 1'b1; tick();
    chk("abort_ptr3", 32'(gnt), 32'h08);

    // Wrap and skip from ptr=4.
    req = 5'h0A; tick();
    chk("wrap_bubble", 32'(gnt), 32'd0);
    tick();
    chk("wrap_1", 32'(gnt), 32'h02);
    tick(); tick();
    chk("wrap_3", 32'(gnt), 32'h08);
    req = 5'h00; tick();

    // Async reset mid-burst.
    req = 5'h01; last = 5'h00; out_ready = 1'b0; tick();
    chk("mid_gnt", 32'(gnt), 32'h01);
    tick(); tick();
    #1 rst_n = 1'b0;
    #1;
    chk("async_gnt", 32'(gnt), 32'd0);
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_sel", 32'(select), 32'd7);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_gnt", 32'(gnt), 32'h01);

    // Stall watchdog.
    pulses = 0; first = -1;
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (timeout) begin
        pulses++;
        if (first < 0) begin
          first = i;
          chk("to_gnt", 32'(gnt), 32'd0);
        end
      end
    end
    chk("to_pulses", 32'(pulses), 32'd1);
    chk("to_first", 32'(first), 32'd16);
`else
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (timeout) pulses++;
    end
    chk("to_pulses", 32'(pulses), 32'd0);
    chk("to_gnt_held", 32'(gnt), 32'h01);
`endif

    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
